// File: rtl/score_sequencer.sv
// Score player: fetches {note,band,dur} words from a synchronous ROM and drives the tone generator.
// Define SCORE_LOOP_EN to repeat the song forever; otherwise the player stops rewound at the end marker.
module score_sequencer #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned BEAT_DIV = 8,
  parameter int unsigned GAP_DIV  = 1000,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned NOTE_W   = 4,
  parameter int unsigned BAND_W   = 3,
  parameter int unsigned DUR_W    = 5,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NOTE_W+BAND_W+DUR_W-1:0] data_i,
  input  logic [ADDR_W-1:0]              song_addr_i,
  input  logic                           pause_i,
  input  logic                           pre_i,
  input  logic                           next_i,
  input  logic [SEL_W-1:0]               len_i,
  input  logic [1:0]                     tempo_i,
  output logic [(2**NOTE_W)-1:0]         signal_o,
  output logic [BAND_W-1:0]              band_o,
  output logic [ADDR_W-1:0]              addr_a_o,
  output logic                           en_o,
  output logic [SEL_W-1:0]               sel_o,
  output logic                           done_o
);

  localparam int unsigned Notes   = 2**NOTE_W;
  localparam int unsigned UnitRaw = CLK_HZ / BEAT_DIV;
  localparam int unsigned GapRaw  = CLK_HZ / GAP_DIV;
  localparam int unsigned Gap     = (GapRaw == 0) ? 1 : GapRaw;

  typedef enum logic [2:0] {StLoad, StWait, StDec, StPlay, StGap} state_e;

  state_e              state_q, state_d;
  logic [Notes-1:0]    signal_q, signal_d;
  logic [BAND_W-1:0]   band_q, band_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                en_q, en_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [31:0]         target_q, target_d;

  logic [NOTE_W-1:0]   note_f;
  logic [BAND_W-1:0]   band_f;
  logic [DUR_W-1:0]    dur_f;
  logic [31:0]         unit_shift, unit_eff;

  assign note_f = data_i[NOTE_W+BAND_W+DUR_W-1 -: NOTE_W];
  assign band_f = data_i[BAND_W+DUR_W-1 -: BAND_W];
  assign dur_f  = data_i[DUR_W-1:0];

  // Very fast tempo settings may shift the unit to zero; never let a note vanish.
  assign unit_shift = 32'(UnitRaw) >> tempo_i;
  assign unit_eff   = (unit_shift == 32'd0) ? 32'd1 : unit_shift;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    signal_d = signal_q;
    band_d   = band_q;
    addr_d   = addr_q;
    en_d     = en_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    target_d = target_q;

    if (next_i) begin
      sel_d    = (sel_q >= len_i) ? '0 : sel_q + SEL_W'(1);
      signal_d = '0;
      cnt_d    = '0;
      state_d  = StLoad;
    end else if (pre_i) begin
      sel_d    = (sel_q == '0) ? len_i : sel_q - SEL_W'(1);
      signal_d = '0;
      cnt_d    = '0;
      state_d  = StLoad;
    end else begin
      if (pause_i) en_d = ~en_q;
      case (state_q)
        StLoad: begin
          addr_d  = song_addr_i;
          state_d = StWait;
        end
        StWait: state_d = StDec;
        StDec: begin
          if (en_q) begin
            if (dur_f == '0) begin
              addr_d  = song_addr_i;
              state_d = StWait;
`ifndef SCORE_LOOP_EN
              en_d    = 1'b0;
`endif
            end else begin
              band_d   = band_f;
              signal_d = (note_f != '0) ? (Notes'(1) << note_f) : '0;
              target_d = 32'(dur_f) * unit_eff;
              cnt_d    = 32'd1;
              state_d  = StPlay;
            end
          end
        end
        StPlay: begin
          if (en_q) begin
            if (cnt_q == target_q) begin
              signal_d = '0;
              cnt_d    = 32'd1;
              state_d  = StGap;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
        end
        StGap: begin
          if (en_q) begin
            if (cnt_q == 32'(Gap)) begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = StWait;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
        end
        default: state_d = StLoad;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      signal_q <= '0;
      band_q   <= '0;
      addr_q   <= '0;
      en_q     <= 1'b0;
      sel_q    <= '0;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      signal_q <= signal_d;
      band_q   <= band_d;
      addr_q   <= addr_d;
      en_q     <= en_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  // The latched note survives a pause, so resuming restores the line without a refetch.
  always_comb begin
    signal_o = en_q ? signal_q : '0;
    band_o   = band_q;
    addr_a_o = addr_q;
    en_o     = en_q;
    sel_o    = sel_q;
    done_o   = (state_q == StDec) && en_q && (dur_f == '0) && !next_i && !pre_i;
  end

endmodule

// File: tb/tb_score_sequencer.sv
// Directed + randomized bench for score_sequencer with a duration-level reference model.
module tb_score_sequencer;

  localparam int unsigned CLK_HZ   = 800;
  localparam int unsigned BEAT_DIV = 8;
  localparam int unsigned GAP_DIV  = 100;
  localparam int unsigned UNIT     = CLK_HZ / BEAT_DIV;
  localparam int unsigned GAP      = CLK_HZ / GAP_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] data;
  logic [4:0]  song_addr;
  logic        pause = 1'b0, pre = 1'b0, next = 1'b0;
  logic [2:0]  len = 3'd2;
  logic [1:0]  tempo = 2'd0;
  logic [15:0] signal_o;
  logic [2:0]  band_o;
  logic [4:0]  addr_a;
  logic        en_o;
  logic [2:0]  sel_o;
  logic        done_o;

  logic [11:0] rom [32];
  logic [4:0]  song_tab [8];

  score_sequencer #(
    .CLK_HZ  (CLK_HZ),
    .BEAT_DIV(BEAT_DIV),
    .GAP_DIV (GAP_DIV),
    .ADDR_W  (5),
    .NOTE_W  (4),
    .BAND_W  (3),
    .DUR_W   (5),
    .SEL_W   (3)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .data_i     (data),
    .song_addr_i(song_addr),
    .pause_i    (pause),
    .pre_i      (pre),
    .next_i     (next),
    .len_i      (len),
    .tempo_i    (tempo),
    .signal_o   (signal_o),
    .band_o     (band_o),
    .addr_a_o   (addr_a),
    .en_o       (en_o),
    .sel_o      (sel_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) data <= rom[addr_a];
  assign song_addr = song_tab[sel_o];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic p_next, input logic p_pre, input logic p_pause);
    next = p_next; pre = p_pre; pause = p_pause;
    tick();
    next = 1'b0; pre = 1'b0; pause = 1'b0;
  endtask

  task automatic wait_sig(input logic [15:0] v, input int lim);
    int k = 0;
    while (signal_o !== v && k < lim) begin tick(); k++; end
  endtask

  task automatic count_const(input logic [15:0] v, input int lim, output int n);
    n = 0;
    while (signal_o === v && n < lim) begin n++; tick(); end
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (done_o !== 1'b1 && k < lim) begin tick(); k++; end
  endtask

  function automatic logic [11:0] w(input int note, input int band, input int dur);
    logic [3:0] nf = note[3:0];
    logic [2:0] bf = band[2:0];
    logic [4:0] df = dur[4:0];
    return {nf, bf, df};
  endfunction

  function automatic int note_len(input int dur, input int tmp);
    int u = UNIT >> tmp;
    if (u == 0) u = 1;
    return dur * u;
  endfunction

  function automatic logic [2:0] sel_after(input logic [2:0] s, input logic [2:0] l,
                                           input bit is_next);
    if (is_next) return (s >= l) ? 3'd0 : s + 3'd1;
    return (s == 3'd0) ? l : s - 3'd1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw;
    int t_r;
    logic [2:0] ms;
    int s1_note [5];
    int s1_band [5];
    int s1_dur  [5];

    for (int i = 0; i < 32; i++) rom[i] = '0;
    for (int i = 0; i < 8; i++) song_tab[i] = 5'((i * 8) % 32);
    rom[0] = w(3, 2, 4);
    rom[1] = w(0, 1, 2);
    for (int k = 0; k < 5; k++) begin
      s1_note[k] = int'($urandom_range(15, 1));
      s1_band[k] = int'($urandom_range(7, 0));
      s1_dur[k]  = int'($urandom_range(3, 1));
      rom[8 + k] = w(s1_note[k], s1_band[k], s1_dur[k]);
    end
    rom[16] = w(5, 3, 4);
    rom[17] = w(6, 1, 4);

    // Reset values
    tick(); tick();
    check("rst_signal", signal_o, 0);
    check("rst_band", band_o, 0);
    check("rst_addr", addr_a, 0);
    check("rst_en", en_o, 0);
    check("rst_sel", sel_o, 0);
    check("rst_done", done_o, 0);
    rst = 1'b0;
    repeat (5) tick();
    check("idle_signal", signal_o, 0);
    check("idle_en", en_o, 0);

    // Song 0: note {3,2,4}, rest {0,1,2}, end marker
    pulse(1'b0, 1'b0, 1'b1);
    check("t1_en", en_o, 1);
    wait_sig(16'h0008, 20);
    check("t1_rise", signal_o, 16'h0008);
    check("t1_band", band_o, 2);
    count_const(16'h0008, 1000, n);
    check("t1_high", n, note_len(4, 0));
    n = 0;
    while (addr_a !== 5'd1 && n < 100) begin n++; tick(); end
    check("t1_gap", n, GAP);
    n = 0; saw = 0;
    while (done_o !== 1'b1 && n < 1000) begin
      if (signal_o !== 16'h0) saw = 1;
      n++; tick();
    end
    check("t2_wait_to_done", n, 2 + note_len(2, 0) + GAP + 1);
    check("t2_rest_silent", saw, 0);
    check("t2_band", band_o, 1);
    tick();
    check("t3_done_pulse", done_o, 0);
    check("t3_rewind", addr_a, song_tab[0]);
    check("t3_stopped_en", en_o, 0);
    saw = 0;
    repeat (50) begin if (signal_o !== 16'h0) saw = 1; tick(); end
    check("t3_stays_silent", saw, 0);

    // Replay, pause 150 clks into the first note for 50+ clks
    pulse(1'b0, 1'b0, 1'b1);
    wait_sig(16'h0008, 20);
    check("t4_rise", signal_o, 16'h0008);
    repeat (149) tick();
    check("t4_before_pause", signal_o, 16'h0008);
    pulse(1'b0, 1'b0, 1'b1);
    saw = 0;
    repeat (50) begin if (signal_o !== 16'h0) saw = 1; tick(); end
    check("t4_paused_silent", saw, 0);
    check("t4_band_held", band_o, 2);
    pulse(1'b0, 1'b0, 1'b1);
    count_const(16'h0008, 1000, n);
    check("t4_total_high", 150 + n, note_len(4, 0));
    wait_done(1000);
    check("t4_done", done_o, 1);
    tick();

    // Song 1: random notes at a random tempo
    tempo = 2'($urandom_range(3, 0));
    t_r = int'(tempo);
    pulse(1'b1, 1'b0, 1'b0);
    check("s1_sel", sel_o, 1);
    tick();
    check("s1_addr", addr_a, song_tab[1]);
    pulse(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      wait_sig(16'(1) << s1_note[k], 60);
      check($sformatf("s1_note%0d", k), signal_o, 16'(1) << s1_note[k]);
      check($sformatf("s1_band%0d", k), band_o, s1_band[k]);
      count_const(16'(1) << s1_note[k], 400, n);
      check($sformatf("s1_high%0d", k), n, note_len(s1_dur[k], t_r));
      if (k < 4) begin
        count_const(16'h0, 100, n);
        check($sformatf("s1_low%0d", k), n, GAP + 2);
      end
    end
    wait_done(100);
    check("s1_done", done_o, 1);
    tick();
    tempo = 2'd0;

    // Song select: directed wrap cases, then random
    ms = 3'd1;
    len = 3'd2;
    pulse(1'b1, 1'b0, 1'b0); ms = 3'd2;
    check("sel_next_to2", sel_o, ms);
    tick(); check("sel_addr_a", addr_a, song_tab[ms]);
    pulse(1'b1, 1'b0, 1'b0); ms = 3'd0;
    check("sel_next_wrap", sel_o, ms);
    tick(); check("sel_addr_b", addr_a, song_tab[ms]);
    pulse(1'b0, 1'b1, 1'b0); ms = 3'd2;
    check("sel_pre_wrap", sel_o, ms);
    tick(); check("sel_addr_c", addr_a, song_tab[ms]);
    pulse(1'b0, 1'b1, 1'b0); ms = 3'd1;
    check("sel_pre", sel_o, ms);
    pulse(1'b1, 1'b1, 1'b0); ms = 3'd2;
    check("sel_both_next_wins", sel_o, ms);
    tick();
    for (int i = 0; i < 12; i++) begin
      int op = int'($urandom_range(2, 0));
      len = 3'($urandom_range(3, 0));
      tick();
      pulse(op != 1, op == 1 || op == 2, 1'b0);
      ms = sel_after(ms, len, op != 1);
      check($sformatf("rnd_sel%0d", i), sel_o, ms);
      tick();
      check($sformatf("rnd_addr%0d", i), addr_a, song_tab[ms]);
    end

    // Song 2 at tempo 1, tempo change mid-note, then reset mid-play
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_sel", sel_o, 0);
    len = 3'd2;
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check("t6_sel", sel_o, 2);
    tempo = 2'd1;
    tick();
    pulse(1'b0, 1'b0, 1'b1);
    wait_sig(16'h0020, 30);
    check("t6_rise", signal_o, 16'h0020);
    count_const(16'h0020, 1000, n);
    check("t6_tempo1_high", n, note_len(4, 1));
    wait_sig(16'h0040, 30);
    repeat (10) tick();
    tempo = 2'd0;
    count_const(16'h0040, 1000, n);
    check("t6_midnote_change", 10 + n, note_len(4, 1));
    wait_done(100);
    check("t6_done", done_o, 1);
    tick();
    pulse(1'b0, 1'b0, 1'b1);
    wait_sig(16'h0020, 30);
    count_const(16'h0020, 1000, n);
    check("t6_tempo0_high", n, note_len(4, 0));
    wait_sig(16'h0040, 30);
    repeat (20) tick();
    check("t5_playing", signal_o, 16'h0040);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_rst_signal", signal_o, 0);
    check("t5_rst_band", band_o, 0);
    check("t5_rst_addr", addr_a, 0);
    check("t5_rst_en", en_o, 0);
    check("t5_rst_sel", sel_o, 0);
    check("t5_rst_done", done_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
